axis_fifo: RTL

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/axis_fifo.sv
// axis_fifo: first-word-fall-through stream FIFO with occupancy count.
// A word pushed on one edge is presented at the head after that edge.
// Ready, valid and head data decode only registered state, so there is
// no combinational path from any input to any output.
// Optional feature: define AXIS_FIFO_OVF_EN to build the sticky overflow
// flag; without it ovf is tied to 0 and no overflow register exists.
module axis_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [WIDTH-1:0]         s_axis_wdata,
  input  logic                     s_axis_wvalid,
  output logic                     s_axis_wready,
  output logic [WIDTH-1:0]         m_axis_wdata,
  output logic                     m_axis_wvalid,
  input  logic                     m_axis_wready,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     ovf_clr,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [AW-1:0] ZERO_PTR = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  // Handshake decode: accept only when not full, present only when not empty.
  always_comb begin
    full_s  = (count_q == FULL_CNT);
    empty_s = (count_q == ZERO_CNT);
    push_s  = s_axis_wvalid && !full_s;
    pop_s   = m_axis_wready && !empty_s;
  end

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= ZERO_PTR;
      rd_ptr_q <= ZERO_PTR;
      count_q  <= ZERO_CNT;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge aclk) begin
    if (push_s && !areset) begin
      mem_q[wr_ptr_q] <= s_axis_wdata;
    end
  end

  assign s_axis_wready = !full_s;
  assign m_axis_wvalid = !empty_s;
  assign m_axis_wdata  = mem_q[rd_ptr_q];
  assign count         = count_q;

`ifdef AXIS_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a write attempt while full sets it, set beats clear.
  always_comb begin
    ovf_d = ovf_q;
    if (s_axis_wvalid && full_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr_s;
  assign unused_ovf_clr_s = ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule
